// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared widths and helpers for the DDS synthesizer datapath
package dds_pkg;

    localparam int SAMPLE_W = 12;
    localparam int VOL_W    = 3;

    // A shift of the full sample width or more leaves nothing of the sample.
    function automatic bit vol_mutes(input int unsigned vol, input int unsigned width);
        return vol >= width;
    endfunction

endpackage

// File: rtl/pwm_dac_out.sv
// rtl/pwm_dac_out.sv - double-buffered sample to single-bit PWM output stage
module pwm_dac_out #(
    parameter int M     = dds_pkg::SAMPLE_W,
    parameter int VOL_W = dds_pkg::VOL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [M-1:0]     sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic [VOL_W-1:0] vol,
    output logic             pwm_out,
    output logic             period_start,
    output logic             underrun
);
    import dds_pkg::*;

    logic [M-1:0] cnt_q, cnt_d;
    logic [M-1:0] duty_q, duty_d;
    logic [M-1:0] hold_q, hold_d;
    logic         hold_full_q, hold_full_d;
    logic         pwm_q, pwm_d;
    logic         period_start_q, period_start_d;
    logic         underrun_q, underrun_d;

    logic         accept;
    logic         wrap;
    logic [M-1:0] attenuated;

    assign sample_ready = !hold_full_q;
    assign accept       = sample_valid && !hold_full_q;
    assign wrap         = ena && (cnt_q == '1);

    always_comb begin
        attenuated = '0;
        if (!vol_mutes(32'(vol), M)) begin
            attenuated = hold_q >> vol;
        end
    end

    always_comb begin
        cnt_d          = cnt_q;
        duty_d         = duty_q;
        hold_d         = hold_q;
        hold_full_d    = hold_full_q;
        pwm_d          = pwm_q;
        period_start_d = wrap;
        underrun_d     = wrap && !hold_full_q;

        if (ena) begin
            cnt_d = cnt_q + M'(1);
            pwm_d = (cnt_q < duty_q);
        end

        // A sample arriving on an empty-buffer wrap lands in hold only; no bypass into duty.
        if (wrap && hold_full_q) begin
            duty_d      = attenuated;
            hold_full_d = 1'b0;
        end

        if (accept) begin
            hold_d      = sample_in;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            duty_q         <= '0;
            hold_q         <= '0;
            hold_full_q    <= 1'b0;
            pwm_q          <= 1'b0;
            period_start_q <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            duty_q         <= duty_d;
            hold_q         <= hold_d;
            hold_full_q    <= hold_full_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
            underrun_q     <= underrun_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = period_start_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_pwm_dac_out.sv
// tb/tb_pwm_dac_out.sv - directed, table-driven bench for pwm_dac_out
module tb_pwm_dac_out;

    localparam int M      = 12;
    localparam int VW     = 3;
    localparam int PERIOD = 4096;

    logic          clk;
    logic          rst_n;
    logic          ena;
    logic [M-1:0]  sample_in;
    logic          sample_valid;
    logic          sample_ready;
    logic [VW-1:0] vol;
    logic          pwm_out;
    logic          period_start;
    logic          underrun;

    int errors = 0;
    int checks = 0;

    pwm_dac_out #(.M(M), .VOL_W(VW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .vol          (vol),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .underrun     (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit            load;
        logic [M-1:0]  s;
        logic [VW-1:0] v;
        int            exp_high;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ps(output bit ready_seen);
        bit found;
        found      = 1'b0;
        ready_seen = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(negedge clk);
            if (period_start) found = 1'b1;
            else if (sample_ready) ready_seen = 1'b1;
        end
        if (!found) check("wait_period_start_timeout", 0, 1);
    endtask

    // Entered at a period_start negedge; leaves at the next period_start negedge.
    task automatic measure(input bit give, input logic [M-1:0] s, input logic [VW-1:0] v,
                           output int high, output int first_low, output int ur_cnt,
                           output int ps_cnt, output bit ps_end);
        if (give) begin
            sample_in    = s;
            vol          = v;
            sample_valid = 1'b1;
        end
        high      = 0;
        first_low = PERIOD;
        ur_cnt    = 0;
        ps_cnt    = 0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            if (i == 0 && give) begin
                check("accept_ready_low", int'(sample_ready), 0);
                sample_valid = 1'b0;
            end
            if (pwm_out) high++;
            else if (first_low == PERIOD) first_low = i;
            ur_cnt += int'(underrun);
            ps_cnt += int'(period_start);
        end
        ps_end = period_start;
    endtask

    initial begin
        vec_t tbl [9];
        int   high, first_low, ur_cnt, ps_cnt, len;
        bit   ps_end, ready_seen, give, done;

        tbl[0] = '{1'b1, 12'h800, 3'd0, 2048};
        tbl[1] = '{1'b1, 12'hFFF, 3'd3, 511};
        tbl[2] = '{1'b1, 12'hFFF, 3'd7, 31};
        tbl[3] = '{1'b1, 12'h000, 3'd0, 0};
        tbl[4] = '{1'b1, 12'hFFF, 3'd0, 4095};
        tbl[5] = '{1'b1, 12'h400, 3'd0, 1024};
        tbl[6] = '{1'b0, 12'h000, 3'd0, 1024};
        tbl[7] = '{1'b0, 12'h000, 3'd0, 1024};
        tbl[8] = '{1'b0, 12'h000, 3'd0, 1024};

        rst_n        = 1'b0;
        ena          = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        vol          = '0;
        repeat (3) @(negedge clk);
        check("reset_ready",        int'(sample_ready), 1);
        check("reset_pwm",          int'(pwm_out), 0);
        check("reset_period_start", int'(period_start), 0);
        check("reset_underrun",     int'(underrun), 0);
        rst_n = 1'b1;

        // First sample: ready drops, returns at the wrap that loads it.
        @(negedge clk);
        sample_in    = tbl[0].s;
        vol          = tbl[0].v;
        sample_valid = 1'b1;
        @(negedge clk);
        check("t1_ready_after_accept", int'(sample_ready), 0);
        sample_valid = 1'b0;
        wait_ps(ready_seen);
        check("t1_ready_stayed_low", int'(ready_seen), 0);
        check("t1_ready_at_wrap",    int'(sample_ready), 1);
        check("t1_no_underrun_at_load", int'(underrun), 0);

        // Each period's sample is supplied during the preceding period.
        for (int i = 0; i < 9; i++) begin
            give = (i < 8) && tbl[i+1].load;
            measure(give, (i < 8) ? tbl[i+1].s : 12'h000, (i < 8) ? tbl[i+1].v : 3'd0,
                    high, first_low, ur_cnt, ps_cnt, ps_end);
            check($sformatf("vec%0d_high", i),      high,      tbl[i].exp_high);
            check($sformatf("vec%0d_first_low", i), first_low, tbl[i].exp_high);
            check($sformatf("vec%0d_underrun", i),  ur_cnt,    give ? 0 : 1);
            check($sformatf("vec%0d_ps_count", i),  ps_cnt,    1);
            check($sformatf("vec%0d_ps_end", i),    int'(ps_end), 1);
        end

        // Back-to-back valid: second sample stalls until the wrap frees the buffer.
        sample_in    = 12'h100;
        vol          = 3'd0;
        sample_valid = 1'b1;
        @(negedge clk);
        check("t5_first_accepted", int'(sample_ready), 0);
        sample_in = 12'h200;
        wait_ps(ready_seen);
        check("t5_stalled_ready_low", int'(ready_seen), 0);
        check("t5_ready_at_wrap",     int'(sample_ready), 1);
        check("t5_no_underrun",       int'(underrun), 0);
        measure(1'b1, 12'h200, 3'd0, high, first_low, ur_cnt, ps_cnt, ps_end);
        check("t5_p1_high",     high,   256);
        check("t5_p1_underrun", ur_cnt, 0);
        measure(1'b0, 12'h000, 3'd0, high, first_low, ur_cnt, ps_cnt, ps_end);
        check("t5_p2_high",     high,   512);
        check("t5_p2_underrun", ur_cnt, 1);

        // Freeze for 100 cycles while pwm_out is high in a 512-duty period.
        len  = 0;
        high = 0;
        done = 1'b0;
        for (int i = 0; i < 6000 && !done; i++) begin
            @(negedge clk);
            len++;
            if (pwm_out) high++;
            if (period_start) done = 1'b1;
            if (len == 100) ena = 1'b0;
            if (len == 200) ena = 1'b1;
        end
        check("t6_period_len",  len,  PERIOD + 100);
        check("t6_high_frozen", high, 512 + 100);
        check("t6_underrun",    int'(underrun), 1);

        // Mid-period asynchronous reset discards the buffered sample.
        sample_in    = 12'h300;
        sample_valid = 1'b1;
        @(negedge clk);
        check("t6_buffered", int'(sample_ready), 0);
        sample_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("t6_pre_reset_pwm", int'(pwm_out), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_pwm",   int'(pwm_out), 0);
        check("async_reset_ready", int'(sample_ready), 1);
        check("async_reset_ps",    int'(period_start), 0);
        check("async_reset_ur",    int'(underrun), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ps(ready_seen);
        check("post_reset_discard_underrun", int'(underrun), 1);
        measure(1'b0, 12'h000, 3'd0, high, first_low, ur_cnt, ps_cnt, ps_end);
        check("post_reset_high", high, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_dac_out.md
Name: pwm_dac_out

Overview:
Output stage of the DDS synthesizer that sits directly downstream of the 5-way waveform select mux. It accepts 12-bit unsigned samples through a valid/ready handshake and double-buffers them. It applies a volume attenuation shift and drives a single-bit PWM pin whose duty cycle tracks the sample. One PWM period is 2^M clock cycles, and one new sample is consumed per period.

Parameters:
M, 12, sample width and PWM counter width; PWM period = 2^M cycles
VOL_W, 3, width of the volume (right-shift) control

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous assert, active-low
ena  input  1  global enable; low freezes the PWM counter
sample_in  input  M  unsigned sample from the waveform select mux
sample_valid  input  1  sample_in is valid this cycle
sample_ready  output  1  hold buffer empty; sample can be accepted
vol  input  VOL_W  attenuation; duty = sample >> vol
pwm_out  output  1  registered PWM output
period_start  output  1  one-cycle pulse marking the first counter cycle of a period
underrun  output  1  one-cycle pulse at a period wrap when no new sample was buffered

Behaviour:
- Reset (rst_n low, asynchronous): cnt=0, duty=0, hold=0, hold_full=0, pwm_out=0, period_start=0, underrun=0. sample_ready reads 1 while in reset and immediately after.
- sample_ready = !hold_full (combinational).
- Transfer happens on a cycle with sample_valid && sample_ready: hold <= sample_in, hold_full <= 1. Acceptance is independent of ena.
- Counter: when ena=1, cnt <= cnt+1, wrapping from 2^M-1 to 0. When ena=0, cnt, pwm_out and duty hold their values, and period_start and underrun are 0.
- Wrap event is the cycle with ena && cnt==2^M-1. At a wrap:
  - If hold_full: duty <= hold >> vol (vol sampled this cycle), hold_full <= 0.
  - Otherwise: duty keeps its previous value and underrun <= 1 for one cycle.
- Transfer and wrap in the same cycle: this can only occur with hold_full=0. The incoming sample goes to hold and is not loaded into duty. underrun still pulses, and the sample is loaded at the next wrap. There is no bypass path.
- period_start <= wrap event, so it is high during the cycle in which cnt==0.
- Compare: pwm_out <= (cnt < duty) on every enabled cycle. Output lags the counter by one cycle.
- Duty boundary values:
  - duty=0 gives constant low.
  - duty=2^M-1 gives 2^M-1 high cycles and 1 low cycle per period.
  - 100% duty is unreachable by design.
- Arithmetic: the shift is a logical right shift of an unsigned M-bit value; the result is zero-extended to M bits. vol >= M yields duty 0.
- vol changes mid-period take effect only at the next load.
- Latency: a sample accepted in period k drives the PWM in period k+1. It appears on pwm_out from the cycle after period_start.
- Reset mid-period aborts the period. pwm_out goes to 0 immediately, and the buffered sample is discarded.

Decomposition:
- Shared dds_pkg holds SAMPLE_W=12 and VOL_W=3, which are reused by the mux and the waveform generators.
- The block stays flat: counter, hold buffer, duty register and comparator are one small module. No sub-module is warranted.

Test Plan:
1. Reset, then present 0x800 with vol=0 and valid held for one cycle.
   - Required: sample_ready drops the next cycle.
   - At the next wrap, ready returns to 1 and period_start pulses.
   - The following period has exactly 2048 pwm_out-high cycles out of 4096.
2. Present 0xFFF with vol=3.
   - Required: the loaded period has exactly 511 high cycles.
   - Repeat with vol=7: exactly 31 high cycles.
3. Load 0x000, then 0xFFF.
   - Required: first period has 0 high cycles.
   - Second period has 4095 high cycles and 1 low cycle, with the low cycle at the end of the period.
4. Load 0x400, then supply no further samples for 3 periods.
   - Required: each of those periods has 1024 high cycles.
   - underrun pulses once per wrap, coincident with each period_start.
5. Hold valid asserted with 0x100, then 0x200 back-to-back.
   - Required: 0x100 is accepted; ready stays 0 with 0x200 stalled until the wrap.
   - 0x200 is accepted the cycle after the wrap.
   - Periods show 256 and then 512 high cycles.
6. Drive ena=0 for 100 cycles mid-period, then pulse rst_n low mid-period.
   - Required: during ena=0, cnt and pwm_out freeze, and the period length extends by exactly 100 cycles.
   - On reset, all outputs go to reset values asynchronously and sample_ready=1.
